// File: rtl/slink_apb_pkg.sv
// rtl/slink_apb_pkg.sv - shared state encoding and constants for the S-Link APB splitter
package slink_apb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2,
    ST_DONE   = 2'd3
  } apb_state_t;

  localparam logic [31:0] DEFAULT_RDATA = 32'h0;

  // A zero-length watchdog still needs a 1-bit register to keep the counter legal.
  function automatic int unsigned cnt_width(input int unsigned max_count);
    return (max_count == 0) ? 1 : $clog2(max_count + 1);
  endfunction

endpackage

// File: rtl/slink_apb_timeout_cnt.sv
// rtl/slink_apb_timeout_cnt.sv - saturating ACCESS-stall counter with clear, enable and expiry flag
module slink_apb_timeout_cnt
  import slink_apb_pkg::*;
#(
  parameter int unsigned MAX_COUNT = 256
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int unsigned   CW   = cnt_width(MAX_COUNT);
  localparam logic [CW-1:0] SAT  = CW'(MAX_COUNT);
  localparam logic [CW-1:0] LAST = (MAX_COUNT == 0) ? '0 : CW'(MAX_COUNT - 1);

  logic [CW-1:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en && (count != SAT)) begin
      count <= count + CW'(1);
    end
  end

  // Expiry looks at the pre-increment value, so the abort lands on the last allowed stall cycle.
  assign expired = (MAX_COUNT != 0) && (count == LAST);

endmodule

// File: rtl/slink_apb_splitter.sv
// rtl/slink_apb_splitter.sv - APB 1-to-N fabric with default slave and stall watchdog
module slink_apb_splitter
  import slink_apb_pkg::*;
#(
  parameter int unsigned NUM_SLAVES         = 4,
  parameter int unsigned ADDR_WIDTH         = 10,
  parameter int unsigned SEL_WIDTH          = 2,
  parameter int unsigned TIMEOUT_CYCLES     = 256,
  parameter bit          SLVERR_ON_UNMAPPED = 1'b1
) (
  input  logic                            apb_clk,
  input  logic                            apb_reset_n,
  input  logic                            apb_psel,
  input  logic                            apb_penable,
  input  logic                            apb_pwrite,
  input  logic [ADDR_WIDTH-1:0]           apb_paddr,
  input  logic [31:0]                     apb_pwdata,
  output logic [31:0]                     apb_prdata,
  output logic                            apb_pready,
  output logic                            apb_pslverr,
  output logic [NUM_SLAVES-1:0]           m_psel,
  output logic                            m_penable,
  output logic                            m_pwrite,
  output logic [ADDR_WIDTH-SEL_WIDTH-1:0] m_paddr,
  output logic [31:0]                     m_pwdata,
  input  logic [32*NUM_SLAVES-1:0]        m_prdata,
  input  logic [NUM_SLAVES-1:0]           m_pready,
  input  logic [NUM_SLAVES-1:0]           m_pslverr,
  output logic                            timeout_flag,
  output logic [SEL_WIDTH-1:0]            timeout_idx,
  input  logic                            timeout_clr
);

  localparam int unsigned OFF_WIDTH = ADDR_WIDTH - SEL_WIDTH;

  apb_state_t            state;
  logic [SEL_WIDTH-1:0]  idx;
  logic [SEL_WIDTH-1:0]  req_idx;
  logic                  req_mapped;
  logic                  setup_req;
  logic [NUM_SLAVES-1:0] req_onehot;
  logic                  slv_ready;
  logic                  slv_err;
  logic [31:0]           slv_rdata;
  logic                  cnt_clr;
  logic                  cnt_en;
  logic                  expired;

  assign setup_req  = apb_psel && !apb_penable;
  assign req_idx    = apb_paddr[ADDR_WIDTH-1 -: SEL_WIDTH];
  assign req_mapped = (32'(req_idx) < NUM_SLAVES);

  // Decode the incoming slot and mux the response of the captured slot.
  always_comb begin
    req_onehot = '0;
    slv_ready  = 1'b0;
    slv_err    = 1'b0;
    slv_rdata  = '0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if (req_idx == SEL_WIDTH'(i)) begin
        req_onehot[i] = 1'b1;
      end
      if (idx == SEL_WIDTH'(i)) begin
        slv_ready = m_pready[i];
        slv_err   = m_pslverr[i];
        slv_rdata = m_prdata[32*i +: 32];
      end
    end
  end

  assign cnt_clr = (state == ST_IDLE) && setup_req && req_mapped;
  assign cnt_en  = (state == ST_ACCESS) && apb_psel && !slv_ready;

  slink_apb_timeout_cnt #(
    .MAX_COUNT (TIMEOUT_CYCLES)
  ) u_timeout_cnt (
    .clk     (apb_clk),
    .rst_n   (apb_reset_n),
    .clr     (cnt_clr),
    .en      (cnt_en),
    .expired (expired)
  );

  always_ff @(posedge apb_clk or negedge apb_reset_n) begin
    if (!apb_reset_n) begin
      state        <= ST_IDLE;
      idx          <= '0;
      m_psel       <= '0;
      m_penable    <= 1'b0;
      m_pwrite     <= 1'b0;
      m_paddr      <= '0;
      m_pwdata     <= '0;
      apb_prdata   <= '0;
      apb_pready   <= 1'b0;
      apb_pslverr  <= 1'b0;
      timeout_flag <= 1'b0;
      timeout_idx  <= '0;
    end else begin
      // A watchdog abort later in this block overrides the clear.
      if (timeout_clr) begin
        timeout_flag <= 1'b0;
      end
      case (state)
        ST_IDLE: begin
          if (setup_req) begin
            idx      <= req_idx;
            m_paddr  <= apb_paddr[OFF_WIDTH-1:0];
            m_pwrite <= apb_pwrite;
            m_pwdata <= apb_pwdata;
            if (req_mapped) begin
              state  <= ST_SETUP;
              m_psel <= req_onehot;
            end else begin
              state       <= ST_DONE;
              apb_pready  <= 1'b1;
              apb_pslverr <= SLVERR_ON_UNMAPPED;
              apb_prdata  <= DEFAULT_RDATA;
            end
          end
        end
        ST_SETUP: begin
          if (!apb_psel) begin
            state  <= ST_IDLE;
            m_psel <= '0;
          end else begin
            state     <= ST_ACCESS;
            m_penable <= 1'b1;
          end
        end
        ST_ACCESS: begin
          if (!apb_psel) begin
            state     <= ST_IDLE;
            m_psel    <= '0;
            m_penable <= 1'b0;
          end else if (slv_ready) begin
            state       <= ST_DONE;
            m_psel      <= '0;
            m_penable   <= 1'b0;
            apb_pready  <= 1'b1;
            apb_prdata  <= slv_rdata;
            apb_pslverr <= slv_err;
          end else if (expired) begin
            state        <= ST_DONE;
            m_psel       <= '0;
            m_penable    <= 1'b0;
            apb_pready   <= 1'b1;
            apb_prdata   <= '0;
            apb_pslverr  <= 1'b1;
            timeout_flag <= 1'b1;
            timeout_idx  <= idx;
          end
        end
        ST_DONE: begin
          state      <= ST_IDLE;
          apb_pready <= 1'b0;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_slink_apb_splitter.sv
// tb/tb_slink_apb_splitter.sv - scoreboard bench for slink_apb_splitter with behavioural slaves
module tb_slink_apb_splitter;

  localparam int NS = 3;
  localparam int AW = 10;
  localparam int SW = 2;
  localparam int OW = AW - SW;
  localparam int TO = 16;

  logic             apb_clk = 1'b0;
  logic             apb_reset_n = 1'b0;
  logic             apb_psel = 1'b0;
  logic             apb_penable = 1'b0;
  logic             apb_pwrite = 1'b0;
  logic [AW-1:0]    apb_paddr = '0;
  logic [31:0]      apb_pwdata = '0;
  logic [31:0]      apb_prdata;
  logic             apb_pready;
  logic             apb_pslverr;
  logic [NS-1:0]    m_psel;
  logic             m_penable;
  logic             m_pwrite;
  logic [OW-1:0]    m_paddr;
  logic [31:0]      m_pwdata;
  logic [32*NS-1:0] m_prdata = '0;
  logic [NS-1:0]    m_pready = '0;
  logic [NS-1:0]    m_pslverr = '0;
  logic             timeout_flag;
  logic [SW-1:0]    timeout_idx;
  logic             timeout_clr = 1'b0;

  always #5 apb_clk = ~apb_clk;

  slink_apb_splitter #(
    .NUM_SLAVES         (NS),
    .ADDR_WIDTH         (AW),
    .SEL_WIDTH          (SW),
    .TIMEOUT_CYCLES     (TO),
    .SLVERR_ON_UNMAPPED (1'b1)
  ) dut (
    .apb_clk      (apb_clk),
    .apb_reset_n  (apb_reset_n),
    .apb_psel     (apb_psel),
    .apb_penable  (apb_penable),
    .apb_pwrite   (apb_pwrite),
    .apb_paddr    (apb_paddr),
    .apb_pwdata   (apb_pwdata),
    .apb_prdata   (apb_prdata),
    .apb_pready   (apb_pready),
    .apb_pslverr  (apb_pslverr),
    .m_psel       (m_psel),
    .m_penable    (m_penable),
    .m_pwrite     (m_pwrite),
    .m_paddr      (m_paddr),
    .m_pwdata     (m_pwdata),
    .m_prdata     (m_prdata),
    .m_pready     (m_pready),
    .m_pslverr    (m_pslverr),
    .timeout_flag (timeout_flag),
    .timeout_idx  (timeout_idx),
    .timeout_clr  (timeout_clr)
  );

  typedef struct {
    int            id;
    int            start;
    int            lat;
    logic          chk_rdata;
    logic [31:0]   rdata;
    logic          slverr;
    logic          tflag;
    logic [SW-1:0] tidx;
    logic [NS-1:0] onehot;
    logic [OW-1:0] off;
  } exp_t;

  exp_t        expq[$];
  exp_t        mon_e;
  int          n_cmp = 0;
  int          n_bad = 0;
  int          cyc = 0;
  int          xid = 0;
  logic        mon_off = 1'b0;
  logic [31:0] refmem[NS][256];
  logic [31:0] smem[NS][256];
  int          slv_wait[NS];
  logic        slv_err[NS];
  int          wcnt = 0;
  logic        model_tflag = 1'b0;
  logic [SW-1:0] model_tidx = '0;

  always @(posedge apb_clk) cyc <= cyc + 1;

  function automatic void chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
    end
  endfunction

  // Behavioural completers: wait slv_wait cycles in ACCESS, then answer from smem.
  always begin
    @(posedge apb_clk);
    #1;
    m_pready  = '0;
    m_pslverr = '0;
    m_prdata  = '0;
    if (apb_reset_n && m_penable && (m_psel != '0)) begin
      for (int i = 0; i < NS; i++) begin
        if (m_psel[i]) begin
          if (wcnt >= slv_wait[i]) begin
            m_pready[i]          = 1'b1;
            m_pslverr[i]         = slv_err[i];
            m_prdata[32*i +: 32] = smem[i][m_paddr];
            if (m_pwrite) smem[i][m_paddr] = m_pwdata;
          end else begin
            wcnt++;
          end
        end
      end
    end else begin
      wcnt = 0;
    end
  end

  // Reference: latency and response follow from slot, wait count and watchdog length alone.
  function automatic exp_t predict(input logic [SW-1:0] idx, input logic [OW-1:0] off, input logic wr,
                                   input logic [31:0] wd, input int waits, input logic err);
    exp_t e;
    e.id = xid; e.start = 0; e.onehot = '0; e.off = off;
    e.chk_rdata = 1'b0; e.rdata = '0; e.slverr = 1'b0;
    if (int'(idx) >= NS) begin
      e.lat = 1; e.slverr = 1'b1; e.chk_rdata = 1'b1;
    end else begin
      e.onehot[idx] = 1'b1;
      if (waits >= TO) begin
        e.lat = TO + 2; e.slverr = 1'b1; e.chk_rdata = 1'b1;
        model_tflag = 1'b1; model_tidx = idx;
      end else begin
        e.lat = 3 + waits; e.slverr = err;
        if (wr) refmem[idx][off] = wd;
        else begin e.chk_rdata = 1'b1; e.rdata = refmem[idx][off]; end
      end
    end
    e.tflag = model_tflag; e.tidx = model_tidx;
    return e;
  endfunction

  always @(negedge apb_clk) begin
    if (apb_reset_n && !mon_off) begin
      if (m_psel != '0) begin
        if (expq.size() == 0) chk("spurious_psel", m_psel, 0);
        else begin
          chk($sformatf("psel x%0d", expq[0].id), m_psel, expq[0].onehot);
          chk($sformatf("paddr x%0d", expq[0].id), m_paddr, expq[0].off);
        end
      end
      if (apb_pready) begin
        if (expq.size() == 0) chk("spurious_pready", apb_pready, 0);
        else begin
          mon_e = expq.pop_front();
          chk($sformatf("latency x%0d", mon_e.id), cyc - mon_e.start, mon_e.lat);
          chk($sformatf("pslverr x%0d", mon_e.id), apb_pslverr, mon_e.slverr);
          if (mon_e.chk_rdata) chk($sformatf("prdata x%0d", mon_e.id), apb_prdata, mon_e.rdata);
          chk($sformatf("tflag x%0d", mon_e.id), timeout_flag, mon_e.tflag);
          if (mon_e.tflag) chk($sformatf("tidx x%0d", mon_e.id), timeout_idx, mon_e.tidx);
          chk($sformatf("done_strobes x%0d", mon_e.id), {m_psel, m_penable}, 0);
        end
      end
    end
  end

  task automatic idle();
    @(posedge apb_clk); #1;
    apb_psel = 1'b0; apb_penable = 1'b0;
  endtask

  task automatic xfer(input logic [SW-1:0] idx, input logic [OW-1:0] off, input logic wr,
                      input logic [31:0] wd, input int waits, input logic err);
    exp_t e;
    int   n;
    if (int'(idx) < NS) begin slv_wait[idx] = waits; slv_err[idx] = err; end
    xid++;
    e = predict(idx, off, wr, wd, waits, err);
    @(posedge apb_clk); #1;
    apb_psel = 1'b1; apb_penable = 1'b0; apb_paddr = {idx, off}; apb_pwrite = wr; apb_pwdata = wd;
    e.start = cyc;
    expq.push_back(e);
    @(posedge apb_clk); #1;
    apb_penable = 1'b1;
    n = 0;
    do begin @(negedge apb_clk); n++; end while (!apb_pready && n < 200);
    if (!apb_pready) begin
      chk($sformatf("pready_timeout x%0d", xid), 0, 1);
      expq.delete();
    end
  endtask

  task automatic clear_flag();
    @(posedge apb_clk); #1; timeout_clr = 1'b1;
    @(posedge apb_clk); #1; timeout_clr = 1'b0;
    model_tflag = 1'b0;
    @(negedge apb_clk);
    chk("flag_cleared", timeout_flag, model_tflag);
  endtask

  int r;
  int waits;

  initial begin
    for (int i = 0; i < NS; i++) begin
      slv_wait[i] = 0; slv_err[i] = 1'b0;
      for (int a = 0; a < 256; a++) begin
        refmem[i][a] = 32'hC0DE_0000 | (i << 8) | a;
        smem[i][a]   = 32'hC0DE_0000 | (i << 8) | a;
      end
    end
    repeat (3) @(negedge apb_clk);
    chk("reset_outputs", {apb_prdata, apb_pready, apb_pslverr, m_psel, m_penable, m_pwrite,
                          m_paddr, m_pwdata, timeout_flag, timeout_idx}, 0);
    apb_reset_n = 1'b1;
    idle();

    xfer(2'd2, 8'h10, 1'b1, 32'hA5A5_0001, 0, 1'b0); idle();
    xfer(2'd2, 8'h10, 1'b0, 32'h0, 0, 1'b0);         idle();
    xfer(2'd1, 8'h04, 1'b0, 32'h0, 5, 1'b1);         idle();
    xfer(2'd3, 8'h33, 1'b0, 32'h0, 0, 1'b0);         idle();
    xfer(2'd0, 8'h08, 1'b0, 32'h0, 1000, 1'b0);      idle();
    clear_flag();
    xfer(2'd2, 8'h55, 1'b0, 32'h0, TO - 1, 1'b0);    idle();
    timeout_clr = 1'b1;
    xfer(2'd1, 8'h66, 1'b1, 32'h1234_5678, TO, 1'b0);
    timeout_clr = 1'b0;
    idle();
    clear_flag();
    xfer(2'd0, 8'h21, 1'b1, 32'hDEAD_BEEF, 0, 1'b0);
    xfer(2'd3, 8'h00, 1'b1, 32'h0, 0, 1'b0);
    xfer(2'd0, 8'h21, 1'b0, 32'h0, 0, 1'b0);         idle();

    mon_off = 1'b1;
    slv_wait[1] = 1000;
    @(posedge apb_clk); #1;
    apb_psel = 1'b1; apb_penable = 1'b0; apb_paddr = {2'd1, 8'h20}; apb_pwrite = 1'b1; apb_pwdata = 32'hFFFF_0000;
    @(posedge apb_clk); #1;
    apb_penable = 1'b1;
    repeat (4) @(posedge apb_clk);
    #3;
    chk("pre_reset_penable", m_penable, 1'b1);
    apb_reset_n = 1'b0;
    #1;
    chk("midreset_outputs", {apb_prdata, apb_pready, apb_pslverr, m_psel, m_penable, m_pwrite,
                             m_paddr, m_pwdata, timeout_flag, timeout_idx}, 0);
    apb_psel = 1'b0; apb_penable = 1'b0;
    model_tflag = 1'b0; model_tidx = '0;
    @(negedge apb_clk);
    apb_reset_n = 1'b1;
    mon_off = 1'b0;
    xfer(2'd1, 8'h04, 1'b0, 32'h0, 2, 1'b0); idle();

    for (int k = 0; k < 40; k++) begin
      r = int'($urandom_range(0, 9));
      waits = (r < 7) ? int'($urandom_range(0, 4)) : ((r == 7) ? TO - 1 : TO + int'($urandom_range(0, 8)));
      xfer(SW'($urandom_range(0, 3)), OW'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
           $urandom, waits, 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 1) == 1) idle();
    end
    idle();
    repeat (5) @(negedge apb_clk);
    chk("queue_drained", expq.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: actual=running expected=finished");
    $fatal(1, "global timeout");
  end

endmodule

// File: doc/slink_apb_splitter.md
# slink_apb_splitter

Parametrised APB fabric that fans one upstream APB target port out to `NUM_SLAVES` downstream APB completers, selected by the top `SEL_WIDTH` address bits. It sits between the SoC APB master and the S-Link register islands (link, BIST, app, …).
- Downstream phases are fully registered: one state machine owns every transfer.
- An address whose slot has no slave is answered locally by a default slave.
- A completer that stalls too long is cut off by a watchdog and reported in sticky status.

## Interface
Parameters:
- `NUM_SLAVES`, 4, number of downstream completers; must be ≤ 2**`SEL_WIDTH`.
- `ADDR_WIDTH`, 10, upstream address width.
- `SEL_WIDTH`, 2, number of top address bits that form the slave index.
- `TIMEOUT_CYCLES`, 256, maximum number of ACCESS cycles with `pready` low before abort; 0 disables the watchdog.
- `SLVERR_ON_UNMAPPED`, 1, when 1 the default slave returns `pslverr`=1.

Ports (one clock; reset is asynchronous and active-low):
- `apb_clk`  in  1  APB clock.
- `apb_reset_n`  in  1  asynchronous active-low reset.
- `apb_psel`, `apb_penable`, `apb_pwrite`  in  1 each  upstream control.
- `apb_paddr`  in  `ADDR_WIDTH`  upstream address.
- `apb_pwdata`  in  32  upstream write data.
- `apb_prdata`  out  32  registered read data.
- `apb_pready`  out  1  registered ready.
- `apb_pslverr`  out  1  registered error.
- `m_psel`  out  `NUM_SLAVES`  one-hot downstream select.
- `m_penable`, `m_pwrite`  out  1 each  shared downstream control.
- `m_paddr`  out  `ADDR_WIDTH-SEL_WIDTH`  shared downstream address; low bits of the captured address.
- `m_pwdata`  out  32  shared downstream write data.
- `m_prdata`  in  `32*NUM_SLAVES`  slave i occupies bits [32i+31:32i].
- `m_pready`, `m_pslverr`  in  `NUM_SLAVES`  per-slave response.
- `timeout_flag`  out  1  sticky; set on a watchdog abort.
- `timeout_idx`  out  `SEL_WIDTH`  index of the slave that caused the last abort.
- `timeout_clr`  in  1  synchronous clear of `timeout_flag`.

## Operation
States are IDLE, SETUP, ACCESS and DONE.

- **IDLE.** On `apb_psel`=1 with `apb_penable`=0, capture `idx`=`paddr[ADDR_WIDTH-1 -: SEL_WIDTH]`, together with the low address bits, `pwrite` and `pwdata`.
  - If `idx` < `NUM_SLAVES`, go to SETUP.
  - Otherwise go to DONE with `pslverr`=`SLVERR_ON_UNMAPPED` and `prdata`=0.
- **SETUP.** Drive `m_psel[idx]`=1 and `m_penable`=0. Go to ACCESS unconditionally.
- **ACCESS.** Drive `m_psel[idx]`=1 and `m_penable`=1.
  - If `m_pready[idx]`=1, register `m_prdata` slice `idx` and `m_pslverr[idx]`, then go to DONE.
  - Otherwise increment the timeout counter. When it equals `TIMEOUT_CYCLES`-1 and `pready` is still low, abort: `pslverr`=1, `prdata`=0, set `timeout_flag`, load `timeout_idx`=`idx`, go to DONE.
- **DONE.** `apb_pready`=1 for exactly one cycle with the registered `prdata`/`pslverr`. All `m_psel`=0 and `m_penable`=0. Go to IDLE.
- **Upstream `apb_psel` falls in SETUP or ACCESS** (protocol violation): return to IDLE next cycle. Downstream strobes drop and no status is set.
- **Timeout counter.** Cleared on entry to SETUP. Width is `$clog2(TIMEOUT_CYCLES+1)`. It never wraps.
- **`timeout_clr` in the same cycle as a new abort:** set wins.
- **`apb_prdata`/`apb_pslverr`** hold their last value outside DONE; they are only meaningful when `pready`=1.
- **`m_pwdata`/`m_paddr`/`m_pwrite`** hold their captured values until the next capture.

## Timing
- **Reset.** Every output is 0 and the state is IDLE. Reset asserted mid-transfer drops all strobes immediately (asynchronously).
- **Mapped read/write, zero-wait slave.** Upstream setup at cycle 0 gives `m_psel` at cycle 1, `m_penable` at cycle 2, slave `pready` at cycle 2, and `apb_pready` at cycle 3.
- **Each slave wait state** adds one cycle.
- **Unmapped access.** `apb_pready` at cycle 1.
- **Timeout abort.** `apb_pready` arrives `TIMEOUT_CYCLES`+2 cycles after the upstream setup cycle.
- **Back-to-back transfers.** A new setup is accepted in the cycle after DONE. This gives a minimum spacing of 4 cycles for mapped accesses and 2 cycles for unmapped ones.

## Structure
- **Package `slink_apb_pkg`:** state encoding localparams (IDLE=2'd0, SETUP=2'd1, ACCESS=2'd2, DONE=2'd3) and the default-slave read value (32'h0).
- **Sub-module `slink_apb_timeout_cnt`:** parametrised saturating counter with clear, enable and `expired` output. Tie `expired`=0 when `TIMEOUT_CYCLES`=0.
- **Main module:** FSM, capture registers and the response mux.

## Test plan
- **Mapped write/read, zero-wait.** Write 32'hA5A5_0001 to slave 2 offset 0x10, then read it back. Required: `m_psel`=4'b0100, `m_paddr`=0x10, `apb_pready` at cycle 3, `apb_prdata`=32'hA5A5_0001, `apb_pslverr`=0.
- **Wait states and slave error.** Slave 1 holds `pready` low for 5 cycles, then asserts `pslverr`=1. Required: `apb_pready` at cycle 8, `apb_pslverr`=1, no timeout.
- **Unmapped slot.** `NUM_SLAVES`=3, access to `idx`=3. Required: `m_psel` stays 0, `apb_pready` at cycle 1, `pslverr`=1, `prdata`=0.
- **Watchdog.** `TIMEOUT_CYCLES`=16, slave 0 never ready. Required: abort with `pready` at cycle 18, `pslverr`=1, `timeout_flag`=1, `timeout_idx`=0, downstream strobes low. Then pulse `timeout_clr` and check the flag is 0.
- **Reset mid-ACCESS.** Assert `apb_reset_n`=0 while a slave is stalled. Required: all outputs are 0 in the same cycle, and the next transfer after release completes normally.
- **Back-to-back.** A mapped transfer immediately followed by an unmapped one. Required: the second setup is accepted in the cycle after DONE, with correct per-transfer responses.
